// File: rtl/link_ddr_downstream_rx.sv
// DDR link receive endpoint: beat assembly, credit-sized word FIFO,
// valid/yumi core handoff and batched toggle-token credit return.
module link_ddr_downstream_rx #(
  parameter int IO_W        = 16,
  parameter int CORE_W      = 64,
  parameter int FIFO_DEPTH  = 8,
  parameter int TOKEN_BATCH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_valid_i,
  input  logic [IO_W-1:0]   io_data_i,
  output logic              core_valid_o,
  output logic [CORE_W-1:0] core_data_o,
  input  logic              core_yumi_i,
  output logic              io_token_o,
  output logic              overflow_o
);

  localparam int N  = CORE_W / IO_W;
  localparam int CW = $clog2(N);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int TW = (TOKEN_BATCH > 1) ?
                      $clog2(TOKEN_BATCH) : 1;
  localparam int PW = CORE_W - IO_W;

  logic [CW-1:0]     beat_cnt;
  logic [PW-1:0]     partial;
  logic [CORE_W-1:0] full_word;
  logic [CORE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [OW-1:0]     count;
  logic [TW-1:0]     deq_cnt;
  logic              token_q;
  logic              ovf_q;

  logic last_beat;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic batch_last;

  assign last_beat  = io_valid_i &
                      (beat_cnt == CW'(N - 1));
  assign full       = (count == OW'(FIFO_DEPTH));
  assign pop        = core_yumi_i & core_valid_o;
  // a pop in the same cycle frees the slot
  assign push       = last_beat & (~full | pop);
  assign drop       = last_beat & full & ~pop;
  assign batch_last = (deq_cnt == TW'(TOKEN_BATCH - 1));
  assign full_word  = {io_data_i, partial};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      partial  <= '0;
    end else if (io_valid_i) begin
      if (last_beat) beat_cnt <= '0;
      else           beat_cnt <= beat_cnt + CW'(1);
      for (int k = 0; k < N - 1; k++) begin
        if (beat_cnt == CW'(k))
          partial[k*IO_W +: IO_W] <= io_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= full_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deq_cnt <= '0;
      token_q <= 1'b0;
    end else if (pop) begin
      if (batch_last) begin
        deq_cnt <= '0;
        token_q <= ~token_q;
      end else begin
        deq_cnt <= deq_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  // head is gated so data reads zero while empty
  assign core_valid_o = (count != '0);
  assign core_data_o  = core_valid_o ?
                        mem[rd_ptr] : '0;
  assign io_token_o   = token_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_link_ddr_downstream_rx.sv
// Directed bench for link_ddr_downstream_rx.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_link_ddr_downstream_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_valid_i = 1'b0;
  logic [15:0] io_data_i = '0;
  logic        core_valid_o;
  logic [63:0] core_data_o;
  logic        core_yumi_i = 1'b0;
  logic        io_token_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  link_ddr_downstream_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .io_valid_i   (io_valid_i),
    .io_data_i    (io_data_i),
    .core_valid_o (core_valid_o),
    .core_data_o  (core_data_o),
    .core_yumi_i  (core_yumi_i),
    .io_token_o   (io_token_o),
    .overflow_o   (overflow_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d,
                      input logic yumi);
    io_valid_i  = 1'b1;
    io_data_i   = d;
    core_yumi_i = yumi;
    step();
    io_valid_i  = 1'b0;
    core_yumi_i = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w,
                           input logic yumi_last);
    for (int b = 0; b < 4; b++) begin
      logic [15:0] d;
      d = w[b*16 +: 16];
      beat(d, (b == 3) ? yumi_last : 1'b0);
    end
  endtask

  task automatic do_pop();
    core_yumi_i = 1'b1;
    step();
    core_yumi_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [63:0] fw(input int i);
    return 64'hA000_0000_0000_0000 | 64'(i);
  endfunction

  initial begin
    #3;
    chk("rst_valid", 64'(core_valid_o), 64'd0);
    chk("rst_data", core_data_o, 64'd0);
    chk("rst_token", 64'(io_token_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    beat(16'h1111, 1'b0);
    beat(16'h2222, 1'b0);
    beat(16'h3333, 1'b0);
    chk("basic_pre_valid", 64'(core_valid_o), 64'd0);
    beat(16'h4444, 1'b0);
    chk("basic_valid", 64'(core_valid_o), 64'd1);
    chk("basic_data", core_data_o,
        64'h4444_3333_2222_1111);
    do_pop();
    chk("basic_popped", 64'(core_valid_o), 64'd0);

    beat(16'h1111, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step();
      chk("gap_valid_a", 64'(core_valid_o), 64'd0);
    end
    beat(16'h2222, 1'b0);
    for (int g = 0; g < 3; g++) step();
    beat(16'h3333, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step();
      chk("gap_valid_b", 64'(core_valid_o), 64'd0);
    end
    beat(16'h4444, 1'b0);
    chk("gap_valid", 64'(core_valid_o), 64'd1);
    chk("gap_data", core_data_o,
        64'h4444_3333_2222_1111);
    do_pop();

    do_reset();
    for (int i = 1; i <= 8; i++) send_word(fw(i), 1'b0);
    chk("fill_ovf", 64'(overflow_o), 64'd0);
    chk("fill_valid", 64'(core_valid_o), 64'd1);
    send_word(fw(9), 1'b0);
    chk("fill_drop_ovf", 64'(overflow_o), 64'd1);
    for (int j = 1; j <= 8; j++) begin
      chk("drain_data", core_data_o, fw(j));
      do_pop();
      chk("drain_token", 64'(io_token_o),
          64'((j / 4) % 2));
    end
    chk("drain_empty", 64'(core_valid_o), 64'd0);
    send_word(fw(10), 1'b0);
    chk("after_valid", 64'(core_valid_o), 64'd1);
    chk("after_data", core_data_o, fw(10));
    chk("ovf_sticky", 64'(overflow_o), 64'd1);
    do_pop();

    do_reset();
    chk("rst2_ovf", 64'(overflow_o), 64'd0);
    for (int i = 1; i <= 8; i++) send_word(fw(i), 1'b0);
    send_word(fw(9), 1'b1);
    chk("simul_ovf", 64'(overflow_o), 64'd0);
    chk("simul_head", core_data_o, fw(2));
    send_word(fw(10), 1'b0);
    chk("simul_still_full", 64'(overflow_o), 64'd1);
    for (int p = 2; p <= 9; p++) begin
      chk("simul_drain", core_data_o, fw(p));
      do_pop();
      chk("simul_token", 64'(io_token_o),
          64'((p / 4) % 2));
    end
    chk("simul_empty", 64'(core_valid_o), 64'd0);

    send_word(64'h1234_5678_9ABC_DEF0, 1'b0);
    beat(16'h5555, 1'b0);
    beat(16'h6666, 1'b0);
    chk("pre_rst_valid", 64'(core_valid_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(core_valid_o), 64'd0);
    chk("mid_rst_data", core_data_o, 64'd0);
    chk("mid_rst_ovf", 64'(overflow_o), 64'd0);
    chk("mid_rst_token", 64'(io_token_o), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    beat(16'hAAAA, 1'b0);
    beat(16'hBBBB, 1'b0);
    beat(16'hCCCC, 1'b0);
    chk("post_rst_pre", 64'(core_valid_o), 64'd0);
    beat(16'hDDDD, 1'b0);
    chk("post_rst_valid", 64'(core_valid_o), 64'd1);
    chk("post_rst_data", core_data_o,
        64'hDDDD_CCCC_BBBB_AAAA);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
